bus_arbiter_rr: RTL
===================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NMASTERS, default 4: number of masters; legal range 1..16.
REQ-002 Parameter DATA_WIDTH, default 32: data bus width; legal values 8, 16, 32, 64.
REQ-003 Parameter ADDR_WIDTH, default 32: address width.
REQ-004 Parameter RR_MODE, default 1: 1 selects round-robin; 0 selects fixed priority, highest index wins.
REQ-005 Parameter TIMEOUT, default 255: BUSY-cycle limit before abort; 0 disables the timeout.
REQ-006 The port list SHALL be as follows; SW denotes DATA_WIDTH/8 throughout.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- master_address  in  ADDR_WIDTH*NMASTERS  per-master address; slice i belongs to master i.
- master_data_i  in  DATA_WIDTH*NMASTERS  per-master write data.
- master_wr  in  SW*NMASTERS  per-master byte-write selects.
- master_enable  in  NMASTERS  per-master request.
- master_data_o  out  DATA_WIDTH  read data, broadcast to all masters.
- master_ready  out  NMASTERS  per-master completion.
- master_error  out  NMASTERS  per-master error or timeout.
- slave_data_i  in  DATA_WIDTH  slave read data.
- slave_ready  in  1  slave completion.
- slave_error  in  1  slave error.
- slave_address  out  ADDR_WIDTH  address of the granted master.
- slave_data_o  out  DATA_WIDTH  write data of the granted master.
- slave_wr  out  SW  byte selects of the granted master.
- slave_enable  out  1  request to the slave.
- grant_o  out  NMASTERS  one-hot registered grant, for debug.

Function
REQ-007 FSM states SHALL be IDLE and BUSY; grant SHALL be a registered one-hot value, all-zero in IDLE.
REQ-008 IDLE with any master_enable set: register the winner into grant and move to BUSY at the next edge; arbitration latency is 1 cycle.
REQ-009 RR_MODE=1: search for the winner starts at index last+1 modulo NMASTERS; the last-grant pointer updates only on entering BUSY.
REQ-010 RR_MODE=0: the winner SHALL be the highest-index master with enable set.
REQ-011 BUSY: slave_address, slave_data_o and slave_wr SHALL carry the granted master's slice; slave_enable SHALL equal the granted master's enable.
REQ-012 In IDLE, slave_enable SHALL be 0, and slave_address, slave_data_o and slave_wr SHALL be 0.
REQ-013 master_data_o SHALL equal slave_data_i at all times.
REQ-014 master_ready[g] SHALL equal slave_ready and master_error[g] SHALL equal slave_error in BUSY, where g is the granted index; all other bits SHALL be 0.
REQ-015 slave_ready or slave_error in BUSY: return to IDLE at the next edge.
- The bus stays idle for at least 1 cycle between grants.
REQ-016 If slave_ready and slave_error are asserted together, both SHALL be forwarded, and the block returns to IDLE.
REQ-017 Granted master drops enable in BUSY: abort, return to IDLE next cycle, no ready or error is issued; slave_enable falls in the same cycle.
REQ-018 Timeout counter: cleared on entering BUSY, incremented each BUSY cycle without ready or error; width SHALL be clog2(TIMEOUT+1).
REQ-019 When the counter equals TIMEOUT in BUSY with no slave ready or error, the block SHALL take the following actions in that cycle.
- Assert master_error[g] for that cycle.
- Force slave_enable to 0.
- Return to IDLE next edge.
REQ-020 Requests from non-granted masters SHALL be held pending, not dropped; the arbiter never pre-empts a granted master.
REQ-021 NMASTERS=1 SHALL degrade to a single-master pass-through with the same 1-cycle grant latency.

Reset
REQ-022 On rst the block SHALL reset to the following values.
- State IDLE, grant 0, timeout counter 0.
- Last-grant pointer NMASTERS-1, so master 0 wins first in round-robin mode.
- All master_ready, master_error and slave_enable outputs 0.
REQ-023 rst asserted in BUSY SHALL abort the transaction with no response issued; rst dominates all other inputs.

Verification
REQ-024 A bench SHALL cover the following directed scenarios (NMASTERS=4, defaults unless stated).
- RR_MODE=1, enable=4'b1111 held, slave_ready one cycle after each grant -> grant order 0,1,2,3,0.
- RR_MODE=0, enable=4'b0110 -> master 2 granted; after its ready, master 2 is granted again while its enable remains set.
- TIMEOUT=8, slave never responds -> master_error[g] pulses exactly 8 BUSY cycles after the grant, then state returns to IDLE.
- Master 1 granted, then drops enable after 2 cycles -> slave_enable=0 in the same cycle, no ready or error, next grant goes to a pending master.
- slave_ready and slave_error asserted together -> both bits set for g only, and the block returns to IDLE.
- rst asserted mid-BUSY -> grant 0 next cycle, and after release master 0 wins from enable=4'b1111.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Multi-master bus arbiter: round-robin or fixed-priority grant, one transaction
// per grant, with abort on enable drop and an optional BUSY-cycle timeout.
module bus_arbiter_rr #(
    parameter int NMASTERS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH*NMASTERS-1:0]   master_address,
    input  logic [DATA_WIDTH*NMASTERS-1:0]   master_data_i,
    input  logic [DATA_WIDTH/8*NMASTERS-1:0] master_wr,
    input  logic [NMASTERS-1:0]              master_enable,
    output logic [DATA_WIDTH-1:0]            master_data_o,
    output logic [NMASTERS-1:0]              master_ready,
    output logic [NMASTERS-1:0]              master_error,
    input  logic [DATA_WIDTH-1:0]            slave_data_i,
    input  logic                             slave_ready,
    input  logic                             slave_error,
    output logic [ADDR_WIDTH-1:0]            slave_address,
    output logic [DATA_WIDTH-1:0]            slave_data_o,
    output logic [DATA_WIDTH/8-1:0]          slave_wr,
    output logic                             slave_enable,
    output logic [NMASTERS-1:0]              grant_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [NMASTERS-1:0] grant;
    logic [IW-1:0]       last;
    logic [CW-1:0]       cnt;

    logic [NMASTERS-1:0] win_oh, hi_oh, lo_oh;
    logic [IW-1:0]       win_idx, hi_idx, lo_idx;
    logic                found_hi, found_lo;
    logic                en_g, resp, timeout_hit;

    // Round-robin: first requester above the last grant, else first at or below it.
    always_comb begin
        win_oh   = '0;
        win_idx  = '0;
        hi_oh    = '0;
        hi_idx   = '0;
        lo_oh    = '0;
        lo_idx   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (master_enable[i]) begin
                if (RR_MODE != 0) begin
                    if (i > int'(last)) begin
                        if (!found_hi) begin
                            found_hi  = 1'b1;
                            hi_idx    = IW'(i);
                            hi_oh     = '0;
                            hi_oh[i]  = 1'b1;
                        end
                    end else if (!found_lo) begin
                        found_lo  = 1'b1;
                        lo_idx    = IW'(i);
                        lo_oh     = '0;
                        lo_oh[i]  = 1'b1;
                    end
                end else begin
                    win_idx   = IW'(i);
                    win_oh    = '0;
                    win_oh[i] = 1'b1;
                end
            end
        end
        if (RR_MODE != 0) begin
            win_oh  = found_hi ? hi_oh : lo_oh;
            win_idx = found_hi ? hi_idx : lo_idx;
        end
    end

    // grant is all-zero in IDLE, so en_g also implies BUSY.
    assign en_g        = |(grant & master_enable);
    assign resp        = en_g & (slave_ready | slave_error);
    assign timeout_hit = (TIMEOUT != 0) && en_g && !slave_ready && !slave_error && (cnt == TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NMASTERS - 1);
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|master_enable) begin
                        state <= BUSY;
                        grant <= win_oh;
                        last  <= win_idx;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (!en_g || resp || timeout_hit) begin
                        state <= IDLE;
                        grant <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        slave_address = '0;
        slave_data_o  = '0;
        slave_wr      = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (grant[i]) begin
                slave_address = slave_address | master_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                slave_data_o  = slave_data_o  | master_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                slave_wr      = slave_wr      | master_wr[i*SW +: SW];
            end
        end
    end

    assign slave_enable  = en_g & ~timeout_hit;
    assign master_data_o = slave_data_i;
    assign master_ready  = grant & {NMASTERS{slave_ready & en_g}};
    assign master_error  = grant & {NMASTERS{(slave_error & en_g) | timeout_hit}};
    assign grant_o       = grant;

endmodule
